// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transaction arbiter: FSM states and response error codes.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RELEASE,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_NACK    = 2'b01,
    RSP_TIMEOUT = 2'b10
  } rsp_err_t;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin grant starting after last_i, with wrap.
// With I2C_ARB_PRIORITY_EN defined, requester 0 wins outright and 1..N-1 rotate.
module i2c_rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [IdW-1:0] cand;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
`ifdef I2C_ARB_PRIORITY_EN
    if (req_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end
`endif
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdW'((32'(last_i) + off) % NUM_REQ);
`ifdef I2C_ARB_PRIORITY_EN
      if (!found && cand != '0 && req_i[cand]) begin
`else
      if (!found && req_i[cand]) begin
`endif
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one single-byte I2C master between NUM_REQ requesters with NACK retry and a watchdog.
// Optional I2C_ARB_PRIORITY_EN gives requester 0 strict priority over the round-robin.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ-1:0]         req_rw_i,
  input  logic [7*NUM_REQ-1:0]       req_addr_i,
  input  logic [8*NUM_REQ-1:0]       req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [7:0]                 rsp_rdata_o,
  output logic [1:0]                 rsp_err_o,
  output logic                       busy_o,
  output logic                       m_req_o,
  output logic                       m_rw_o,
  output logic [6:0]                 m_addr_o,
  output logic [7:0]                 m_wdata_o,
  input  logic [7:0]                 m_rdata_i,
  input  logic                       m_done_i,
  input  logic                       m_ack_error_i
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned TmrW   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  arb_state_t        state_q, state_d;
  logic [IdW-1:0]    last_q, last_d;
  logic [IdW-1:0]    id_q, id_d;
  logic              rw_q, rw_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  rsp_err_t          err_q, err_d;
  logic              nack_q, nack_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TmrW-1:0]   timer_q, timer_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     gnt_idx;
  logic               gnt_any;

  i2c_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    nack_d      = nack_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    req_ready_o = '0;
    rsp_valid_o = 1'b0;
    m_req_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ready is gated by rst_n so no accept can be signalled while reset is asserted.
        if (gnt_any && rst_n) begin
          req_ready_o = gnt;
          id_d        = gnt_idx;
          rw_d        = req_rw_i[gnt_idx];
          addr_d      = req_addr_i[7*int'(gnt_idx) +: 7];
          wdata_d     = req_wdata_i[8*int'(gnt_idx) +: 8];
          rdata_d     = 8'h00;
          err_d       = RSP_OK;
          nack_d      = 1'b0;
          retry_d     = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        m_req_o = 1'b1;
        timer_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        m_req_o = 1'b1;
        timer_d = timer_q + TmrW'(1);
        if (m_done_i) begin
          if (rw_q) rdata_d = m_rdata_i;
          nack_d  = m_ack_error_i;
          state_d = RELEASE;
        end else if (timer_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = RSP_TIMEOUT;
          state_d = RESP;
        end
      end
      RELEASE: begin
        // Hold here until done falls so a level-held done is counted once.
        if (!m_done_i) begin
          if (nack_q && (retry_q < RetryW'(MAX_RETRY))) begin
            retry_d = retry_q + RetryW'(1);
            state_d = ISSUE;
          end else begin
            err_d   = nack_q ? RSP_NACK : RSP_OK;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
`ifdef I2C_ARB_PRIORITY_EN
        if (id_q != '0) last_d = id_q;
`else
        last_d = id_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IdW'(NUM_REQ - 1);
      id_q    <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= RSP_OK;
      nack_q  <= 1'b0;
      retry_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      nack_q  <= nack_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign m_rw_o      = rw_q;
  assign m_addr_o    = addr_q;
  assign m_wdata_o   = wdata_q;
  assign rsp_id_o    = id_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: 4 requesters, MAX_RETRY = 2, TIMEOUT_CYCLES = 100.
module tb_i2c_txn_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Tmo  = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NReq-1:0]  req_valid_i;
  logic [NReq-1:0]  req_ready_o;
  logic [NReq-1:0]  req_rw_i;
  logic [7*NReq-1:0] req_addr_i;
  logic [8*NReq-1:0] req_wdata_i;
  logic             rsp_valid_o;
  logic [1:0]       rsp_id_o;
  logic [7:0]       rsp_rdata_o;
  logic [1:0]       rsp_err_o;
  logic             busy_o;
  logic             m_req_o;
  logic             m_rw_o;
  logic [6:0]       m_addr_o;
  logic [7:0]       m_wdata_o;
  logic [7:0]       m_rdata_i;
  logic             m_done_i;
  logic             m_ack_error_i;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ready_cnt = 0;
  int mreq_rises = 0;
  int rsp_cnt = 0;
  int busy_bad = 0;
  logic mreq_prev = 1'b0;

  i2c_txn_arbiter #(
    .NUM_REQ        (NReq),
    .MAX_RETRY      (2),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_rw_i      (req_rw_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_id_o      (rsp_id_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .busy_o        (busy_o),
    .m_req_o       (m_req_o),
    .m_rw_o        (m_rw_o),
    .m_addr_o      (m_addr_o),
    .m_wdata_o     (m_wdata_o),
    .m_rdata_i     (m_rdata_i),
    .m_done_i      (m_done_i),
    .m_ack_error_i (m_ack_error_i)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (req_ready_o != '0) ready_cnt++;
    if (m_req_o && !mreq_prev) mreq_rises++;
    mreq_prev = m_req_o;
    if (rsp_valid_o) rsp_cnt++;
    if ((m_req_o || rsp_valid_o) && !busy_o) busy_bad++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic rw, input logic [6:0] a,
                         input logic [7:0] d);
    req_valid_i[i]          = v;
    req_rw_i[i]             = rw;
    req_addr_i[7*i +: 7]    = a;
    req_wdata_i[8*i +: 8]   = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Engine model: waits for m_req_o, then holds done for 'hold' cycles.
  task automatic serve(input logic nack, input logic [7:0] rd, input int delay, input int hold);
    for (int i = 0; i < 20 && !m_req_o; i++) step();
    if (!m_req_o) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL engine_req_wait: m_req_o=%0b, required 1 within 20 cycles", m_req_o);
    end else begin
      repeat (delay) step();
      m_done_i      = 1'b1;
      m_ack_error_i = nack;
      m_rdata_i     = rd;
      repeat (hold) step();
      m_done_i      = 1'b0;
      m_ack_error_i = 1'b0;
      m_rdata_i     = 8'h00;
    end
  endtask

  task automatic wait_rsp(output logic got);
    for (int i = 0; i < 300 && !rsp_valid_o; i++) step();
    got = rsp_valid_o;
  endtask

  task automatic test_reset();
    logic [34:0] outs;
    rst_n = 1'b0;
    step();
    req_valid_i = '1;
    #1;
    outs = {req_ready_o, busy_o, m_req_o, m_rw_o, m_addr_o, m_wdata_o, rsp_valid_o, rsp_id_o,
            rsp_rdata_o, rsp_err_o};
    vec_cnt++;
    if (outs !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    req_valid_i = '0;
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if (busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_busy: got %b, required 0", busy_o);
    end
  endtask

  task automatic test_write_ack();
    logic got;
    int base_ready;
    set_req(2, 1'b1, 1'b0, 7'h50, 8'hA5);
    #1;
    base_ready = ready_cnt;
    vec_cnt++;
    if (req_ready_o !== 4'b0100) begin
      err_cnt++;
      $display("FAIL wr_ready: got %b, required 0100", req_ready_o);
    end
    step();
    req_valid_i[2] = 1'b0;
    vec_cnt++;
    if ({m_req_o, m_rw_o, m_addr_o, m_wdata_o} !== {1'b1, 1'b0, 7'h50, 8'hA5}) begin
      err_cnt++;
      $display("FAIL wr_fields: got req=%b rw=%b addr=%h wdata=%h, required 1 0 50 a5",
               m_req_o, m_rw_o, m_addr_o, m_wdata_o);
    end
    serve(1'b0, 8'hFF, 3, 2);
    wait_rsp(got);
    vec_cnt++;
    if ({got, rsp_id_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 2'd2, 2'b00, 8'h00}) begin
      err_cnt++;
      $display("FAIL wr_rsp: got v=%b id=%0d err=%b rdata=%h, required 1 2 00 00",
               got, rsp_id_o, rsp_err_o, rsp_rdata_o);
    end
    step();
    vec_cnt++;
    if (ready_cnt - base_ready !== 1) begin
      err_cnt++;
      $display("FAIL wr_ready_pulses: got %0d, required 1", ready_cnt - base_ready);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic got;
    logic [3:0] one;
    int base_busy;
    do_reset();
    base_busy = busy_bad;
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b0, 7'(8'h10 + k), 8'(8'h20 + k));
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 10; i++) begin
        #1;
        if (req_ready_o != '0) break;
        step();
      end
      one = 4'(1 << exp_seq[t]);
      vec_cnt++;
      if (req_ready_o !== one) begin
        err_cnt++;
        $display("FAIL rr_ready[%0d]: got %b, required %b", t, req_ready_o, one);
      end
      step();
      vec_cnt++;
      if (m_addr_o !== 7'(16 + exp_seq[t])) begin
        err_cnt++;
        $display("FAIL rr_addr[%0d]: got %h, required %h", t, m_addr_o, 7'(16 + exp_seq[t]));
      end
      serve(1'b0, 8'h00, 1, 1);
      wait_rsp(got);
      vec_cnt++;
      if ({got, rsp_id_o} !== {1'b1, 2'(exp_seq[t])}) begin
        err_cnt++;
        $display("FAIL rr_rsp_id[%0d]: got v=%b id=%0d, required 1 %0d",
                 t, got, rsp_id_o, exp_seq[t]);
      end
      if (t == 4) req_valid_i = '0;
      step();
    end
    vec_cnt++;
    if (busy_bad - base_busy !== 0) begin
      err_cnt++;
      $display("FAIL rr_busy: got %0d low-busy cycles, required 0", busy_bad - base_busy);
    end
  endtask

  task automatic test_nack_retry();
    logic got;
    int base_rise;
    int base_rsp;
    set_req(1, 1'b1, 1'b0, 7'h33, 8'h5A);
    #1;
    base_rise = mreq_rises;
    base_rsp  = rsp_cnt;
    step();
    req_valid_i[1] = 1'b0;
    repeat (3) serve(1'b1, 8'h00, 2, 1);
    wait_rsp(got);
    vec_cnt++;
    if ({got, rsp_id_o, rsp_err_o} !== {1'b1, 2'd1, 2'b01}) begin
      err_cnt++;
      $display("FAIL nack_rsp: got v=%b id=%0d err=%b, required 1 1 01", got, rsp_id_o, rsp_err_o);
    end
    repeat (10) step();
    vec_cnt++;
    if (mreq_rises - base_rise !== 3) begin
      err_cnt++;
      $display("FAIL nack_issues: got %0d, required 3", mreq_rises - base_rise);
    end
    vec_cnt++;
    if (rsp_cnt - base_rsp !== 1) begin
      err_cnt++;
      $display("FAIL nack_rsp_count: got %0d, required 1", rsp_cnt - base_rsp);
    end
  endtask

  task automatic test_read_hold();
    logic got;
    int base_rsp;
    set_req(1, 1'b1, 1'b1, 7'h2A, 8'h00);
    #1;
    base_rsp = rsp_cnt;
    step();
    req_valid_i[1] = 1'b0;
    vec_cnt++;
    if ({m_req_o, m_rw_o, m_addr_o} !== {1'b1, 1'b1, 7'h2A}) begin
      err_cnt++;
      $display("FAIL rd_fields: got req=%b rw=%b addr=%h, required 1 1 2a",
               m_req_o, m_rw_o, m_addr_o);
    end
    serve(1'b0, 8'h3C, 2, 50);
    vec_cnt++;
    if (rsp_cnt - base_rsp !== 0) begin
      err_cnt++;
      $display("FAIL rd_early_rsp: got %0d responses while done held, required 0",
               rsp_cnt - base_rsp);
    end
    wait_rsp(got);
    vec_cnt++;
    if ({got, rsp_id_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 2'd1, 2'b00, 8'h3C}) begin
      err_cnt++;
      $display("FAIL rd_rsp: got v=%b id=%0d err=%b rdata=%h, required 1 1 00 3c",
               got, rsp_id_o, rsp_err_o, rsp_rdata_o);
    end
    repeat (10) step();
    vec_cnt++;
    if (rsp_cnt - base_rsp !== 1) begin
      err_cnt++;
      $display("FAIL rd_rsp_count: got %0d, required 1", rsp_cnt - base_rsp);
    end
  endtask

  task automatic test_timeout();
    int base_rise;
    int cnt = 0;
    set_req(3, 1'b1, 1'b0, 7'h44, 8'h99);
    #1;
    base_rise = mreq_rises;
    step();
    req_valid_i[3] = 1'b0;
    for (int i = 0; i < 300 && m_req_o; i++) begin
      cnt++;
      step();
    end
    // ISSUE cycle plus TIMEOUT_CYCLES cycles in WAIT_DONE.
    vec_cnt++;
    if (cnt !== Tmo + 1) begin
      err_cnt++;
      $display("FAIL tmo_req_cycles: got %0d, required %0d", cnt, Tmo + 1);
    end
    vec_cnt++;
    if ({rsp_valid_o, rsp_id_o, rsp_err_o} !== {1'b1, 2'd3, 2'b10}) begin
      err_cnt++;
      $display("FAIL tmo_rsp: got v=%b id=%0d err=%b, required 1 3 10",
               rsp_valid_o, rsp_id_o, rsp_err_o);
    end
    repeat (20) step();
    vec_cnt++;
    if (mreq_rises - base_rise !== 1) begin
      err_cnt++;
      $display("FAIL tmo_no_retry: got %0d issues, required 1", mreq_rises - base_rise);
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    logic [34:0] outs;
    int base_rsp;
    set_req(0, 1'b1, 1'b0, 7'h01, 8'h02);
    #1;
    step();
    req_valid_i[0] = 1'b0;
    serve(1'b0, 8'h00, 1, 1);
    wait_rsp(got);
    step();
    set_req(2, 1'b1, 1'b0, 7'h12, 8'h34);
    #1;
    step();
    req_valid_i[2] = 1'b0;
    step();
    step();
    base_rsp = rsp_cnt;
    rst_n = 1'b0;
    #1;
    outs = {req_ready_o, busy_o, m_req_o, m_rw_o, m_addr_o, m_wdata_o, rsp_valid_o, rsp_id_o,
            rsp_rdata_o, rsp_err_o};
    vec_cnt++;
    if (outs !== '0) begin
      err_cnt++;
      $display("FAIL midrst_outputs: got %h, required 0", outs);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if (rsp_cnt - base_rsp !== 0) begin
      err_cnt++;
      $display("FAIL midrst_rsp: got %0d responses, required 0", rsp_cnt - base_rsp);
    end
    req_valid_i = 4'b0111;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b0001) begin
      err_cnt++;
      $display("FAIL midrst_grant: got %b, required 0001", req_ready_o);
    end
    req_valid_i = '0;
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid_i   = '0;
    req_rw_i      = '0;
    req_addr_i    = '0;
    req_wdata_i   = '0;
    m_rdata_i     = 8'h00;
    m_done_i      = 1'b0;
    m_ack_error_i = 1'b0;
    test_reset();
    test_write_ack();
    test_round_robin();
    test_nack_retry();
    test_read_hold();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one single-byte I2C master engine between NUM_REQ independent requesters.
- Arbitrates between them with round-robin.
- Sequences each transaction on the engine's req/done handshake, retries on NACK up to MAX_RETRY times, and aborts on a watchdog timeout.
- Sits between host-side agents (CSR block, sensor pollers) and the I2C master, and returns a tagged response per transaction.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- MAX_RETRY, 2: re-issues allowed after a NACK; 0 means no retry.
- TIMEOUT_CYCLES, 65535: clk cycles allowed in WAIT_DONE before abort; must be ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid_i  in  NUM_REQ  per-requester transaction request
- req_ready_o  out  NUM_REQ  one-hot accept pulse
- req_rw_i  in  NUM_REQ  per-requester direction; 0 = write, 1 = read
- req_addr_i  in  7*NUM_REQ  packed 7-bit slave addresses; requester i occupies bits [7i+6:7i]
- req_wdata_i  in  8*NUM_REQ  packed write data; requester i occupies bits [8i+7:8i]
- rsp_valid_o  out  1  single-cycle response strobe
- rsp_id_o  out  $clog2(NUM_REQ)  requester index of the response
- rsp_rdata_o  out  8  read data; 0 for writes
- rsp_err_o  out  2  00 = OK, 01 = NACK, 10 = TIMEOUT
- busy_o  out  1  high whenever state != IDLE
- m_req_o  out  1  engine request
- m_rw_o  out  1  engine direction
- m_addr_o  out  7  engine slave address
- m_wdata_o  out  8  engine write data
- m_rdata_i  in  8  engine read data
- m_done_i  in  1  engine completion; a level that may stay high for many cycles
- m_ack_error_i  in  1  engine NACK flag

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock clk.
  - All outputs go to 0; state = IDLE.
  - last_grant = NUM_REQ-1, so the first grant goes to requester 0.
  - retry_cnt = 0; timer = 0.
- Reset mid-transaction: m_req_o drops immediately and no response is emitted.
- Accept handshake:
  - req_ready_o[g] is combinational and high only in IDLE, for the granted requester g.
  - Transfer occurs when req_valid_i[g] && req_ready_o[g].
  - Requesters hold valid and fields stable until ready.
  - Fields are latched on accept.
- States:
  - IDLE:
    - If any valid, select g = first set bit scanning last_grant+1 upward with wrap.
    - Pulse req_ready_o[g]; latch rw/addr/wdata/id; retry_cnt = 0; go to ISSUE.
  - ISSUE:
    - Assert m_req_o and drive the m_* fields from the latched values.
    - Clear timer; go to WAIT_DONE.
  - WAIT_DONE:
    - m_req_o stays 1 and timer increments.
    - First cycle with m_done_i = 1: deassert m_req_o, capture m_rdata_i (reads only), set nack = m_ack_error_i, go to RELEASE. m_ack_error_i is sampled only in this cycle.
    - Else, if timer == TIMEOUT_CYCLES-1: deassert m_req_o, set err = TIMEOUT, go to RESP. Timeouts are never retried.
    - If done and timeout coincide, done wins.
  - RELEASE:
    - Wait for m_done_i == 0, so a level-held done is not double-counted.
    - Then, if nack && retry_cnt < MAX_RETRY: retry_cnt++, go to ISSUE.
    - Otherwise set err (NACK or OK) and go to RESP.
  - RESP:
    - rsp_valid_o = 1 for exactly one cycle, with id/rdata/err valid in that cycle.
    - last_grant = id; go to IDLE.
- Responses have no backpressure.
- Throughput: at most one transaction in flight. The next grant is possible no earlier than the cycle after RESP.
- The m_* fields hold their values from ISSUE until the next accept.
- A requester deasserting valid while not granted is legal; it is simply skipped.

Optional Feature:
- Macro: I2C_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority; whenever req_valid_i[0] is set in IDLE it is granted. Requesters 1..NUM_REQ-1 round-robin among themselves, and last_grant is not updated by requester-0 grants.
- Undefined: pure round-robin across all requesters as above.

Decomposition:
- Package i2c_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT_DONE, RELEASE, RESP}.
  - rsp_err_t enum {RSP_OK = 2'b00, RSP_NACK = 2'b01, RSP_TIMEOUT = 2'b10}.
- Sub-module i2c_rr_arbiter: purely combinational one-hot grant from a request vector and last_grant. It contains the priority variant under the macro.

Test Plan:
- Req 2 write, addr 0x50, wdata 0xA5, slave ACKs -> one ready pulse on bit 2; m_addr_o = 0x50, m_rw_o = 0, m_wdata_o = 0xA5; after done falls, rsp_valid_o with id = 2, err = 00.
- All 4 valid continuously after reset -> grant order 0, 1, 2, 3, 0; each rsp_id_o matches; busy_o never drops mid-transaction.
- Write where the slave always NACKs, MAX_RETRY = 2 -> exactly 3 m_req_o assertions, then one response with err = 01.
- Read from req 1, slave returns 0x3C -> rsp_rdata_o = 0x3C, err = 00. m_done_i held high for 50 cycles -> exactly one response.
- m_done_i never asserts, TIMEOUT_CYCLES = 100 -> m_req_o falls 100 cycles after ISSUE; err = 10; no retry.
- rst_n pulsed low during WAIT_DONE -> all outputs 0 asynchronously, no rsp_valid_o; the next grant after reset goes to requester 0.
